// File: rtl/lcd_rx_capture.sv
// Passive receiver for a 4/8-bit HD44780-style LCD bus: decodes strobed
// nibbles/bytes and keeps a 2-row shadow of the characters on the panel.
module lcd_rx_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int ROW_LEN     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic       lcd4,
  input  logic       lcd5,
  input  logic       lcd6,
  input  logic       lcd7,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_valid,
  output logic       byte_rs,
  output logic [7:0] byte_data,
  output logic       four_bit_mode,
  output logic       display_on,
  output logic       clear_busy,
  output logic       err_dropped
);
  localparam int         DEPTH   = 2 * ROW_LEN;
  localparam int         IW      = $clog2(DEPTH);
  localparam logic [6:0] ROW_END = 7'(ROW_LEN);
  localparam logic [6:0] ROW1    = 7'h40;
  localparam logic [7:0] BLANK   = 8'h20;

  // Hole addresses (0x28-0x3F, 0x68-0x7F) just count up; only the row ends jump.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      case (ac)
        7'h27:   nxt = 7'h40;
        7'h67:   nxt = 7'h00;
        7'h7F:   nxt = 7'h00;
        default: nxt = ac + 7'd1;
      endcase
    end else begin
      case (ac)
        7'h40:   nxt = 7'h27;
        7'h00:   nxt = 7'h67;
        default: nxt = ac - 7'd1;
      endcase
    end
    return nxt;
  endfunction

  logic [6:0]    sync_q [SYNC_STAGES];
  logic          e_prev_q;
  logic [7:0]    shadow_q [DEPTH];
  logic [6:0]    ac_q, ac_d;
  logic          inc_q, inc_d;
  logic          phase_hi_q, phase_hi_d;
  logic [3:0]    hi_nib_q, hi_nib_d;
  logic          cgram_q, cgram_d;
  logic [IW-1:0] clr_cnt_q, clr_cnt_d;
  logic          four_q, four_d;
  logic          disp_q, disp_d;
  logic          busy_q, busy_d;
  logic          bv_q, bv_d;
  logic          brs_q, brs_d;
  logic [7:0]    bdata_q, bdata_d;
  logic          err_q, err_d;
  logic [7:0]    rd_q;

  logic [6:0]    samp_s;
  logic          strobe_s;
  logic          complete_s;
  logic [7:0]    byte_s;
  logic          we_s;
  logic [IW-1:0] widx_s;
  logic [7:0]    wdata_s;

  assign samp_s   = sync_q[SYNC_STAGES-1];
  // samp_s = {e, rs, rw, d7..d4}; read cycles never count as strobes.
  assign strobe_s = e_prev_q & ~samp_s[6] & ~samp_s[4];

  // Next-state: clear sweep, nibble assembly, instruction decode and data writes.
  always_comb begin
    ac_d       = ac_q;
    inc_d      = inc_q;
    phase_hi_d = phase_hi_q;
    hi_nib_d   = hi_nib_q;
    cgram_d    = cgram_q;
    clr_cnt_d  = clr_cnt_q;
    four_d     = four_q;
    disp_d     = disp_q;
    busy_d     = busy_q;
    bv_d       = 1'b0;
    brs_d      = brs_q;
    bdata_d    = bdata_q;
    err_d      = 1'b0;
    complete_s = 1'b0;
    byte_s     = 8'h00;
    we_s       = 1'b0;
    widx_s     = '0;
    wdata_s    = BLANK;

    if (busy_q) begin
      we_s   = 1'b1;
      widx_s = clr_cnt_q;
      err_d  = strobe_s;
      if (clr_cnt_q == IW'(DEPTH - 1)) begin
        busy_d    = 1'b0;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + IW'(1);
      end
    end else if (strobe_s) begin
      if (!four_q) begin
        complete_s = 1'b1;
        byte_s     = {samp_s[3:0], 4'h0};
      end else if (phase_hi_q) begin
        hi_nib_d   = samp_s[3:0];
        phase_hi_d = 1'b0;
      end else begin
        complete_s = 1'b1;
        byte_s     = {hi_nib_q, samp_s[3:0]};
        phase_hi_d = 1'b1;
      end
    end else begin
      bv_d = 1'b0;
    end

    if (complete_s) begin
      bv_d    = 1'b1;
      brs_d   = samp_s[5];
      bdata_d = byte_s;
      if (!samp_s[5]) begin
        casez (byte_s)
          8'b1???????: begin ac_d = byte_s[6:0]; cgram_d = 1'b0; end
          8'b01??????: cgram_d = 1'b1;
          8'b001?????: begin four_d = ~byte_s[4]; phase_hi_d = 1'b1; end
          8'b0001????: ;
          8'b00001???: disp_d = byte_s[2];
          8'b000001??: inc_d = byte_s[1];
          8'b0000001?: begin ac_d = 7'h00; cgram_d = 1'b0; end
          8'b00000001: begin
            ac_d      = 7'h00;
            inc_d     = 1'b1;
            cgram_d   = 1'b0;
            busy_d    = 1'b1;
            clr_cnt_d = '0;
          end
          default: ;
        endcase
      end else if (!cgram_q) begin
        wdata_s = byte_s;
        if (ac_q < ROW_END) begin
          we_s   = 1'b1;
          widx_s = IW'(ac_q);
        end else if (ac_q >= ROW1 && ac_q < ROW1 + ROW_END) begin
          we_s   = 1'b1;
          widx_s = IW'(ac_q - ROW1) + IW'(ROW_LEN);
        end else begin
          we_s = 1'b0;
        end
        ac_d = ac_step(ac_q, inc_q);
      end else begin
        ac_d = ac_q;
      end
    end else begin
      complete_s = 1'b0;
    end
  end

  // State, synchronizers, shadow array and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 7'h00;
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= BLANK;
      e_prev_q   <= 1'b0;
      ac_q       <= 7'h00;
      inc_q      <= 1'b1;
      phase_hi_q <= 1'b1;
      hi_nib_q   <= 4'h0;
      cgram_q    <= 1'b0;
      clr_cnt_q  <= '0;
      four_q     <= 1'b0;
      disp_q     <= 1'b0;
      busy_q     <= 1'b0;
      bv_q       <= 1'b0;
      brs_q      <= 1'b0;
      bdata_q    <= 8'h00;
      err_q      <= 1'b0;
      rd_q       <= BLANK;
    end else begin
      sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd7, lcd6, lcd5, lcd4};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_prev_q   <= samp_s[6];
      ac_q       <= ac_d;
      inc_q      <= inc_d;
      phase_hi_q <= phase_hi_d;
      hi_nib_q   <= hi_nib_d;
      cgram_q    <= cgram_d;
      clr_cnt_q  <= clr_cnt_d;
      four_q     <= four_d;
      disp_q     <= disp_d;
      busy_q     <= busy_d;
      bv_q       <= bv_d;
      brs_q      <= brs_d;
      bdata_q    <= bdata_d;
      err_q      <= err_d;
      rd_q       <= shadow_q[IW'(rd_addr)];
      if (we_s) shadow_q[widx_s] <= wdata_s;
    end
  end

  assign rd_data       = rd_q;
  assign byte_valid    = bv_q;
  assign byte_rs       = brs_q;
  assign byte_data     = bdata_q;
  assign four_bit_mode = four_q;
  assign display_on    = disp_q;
  assign clear_busy    = busy_q;
  assign err_dropped   = err_q;
endmodule
